// File: rtl/rmap_rx_arbiter_if.sv
// Receive-side bundle of rmap_rx_arbiter: per-channel FWFT FIFO heads and pops,
// plus the merged FWFT output port read by the RMAP target.
interface rmap_rx_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic [9*NUM_CH-1:0] chDataOut;
  logic [NUM_CH-1:0]   chEmpty;
  logic [NUM_CH-1:0]   chReadEnable;
  logic [8:0]          rxDataOut;
  logic                rxEmpty;
  logic                rxReadEnable;

  modport master (
    input  chDataOut, chEmpty, rxReadEnable,
    output chReadEnable, rxDataOut, rxEmpty
  );

  modport slave (
    output chDataOut, chEmpty, rxReadEnable,
    input  chReadEnable, rxDataOut, rxEmpty
  );
endinterface

// File: rtl/rmap_rx_arbiter.sv
// Packet-wise round-robin merge of SpaceWire receive FIFOs with logical-address filtering.
// Define RMAP_RX_TIMEOUT_EN to terminate packets stalled mid-stream with a forced EEP.
module rmap_rx_arbiter #(
  parameter int  NUM_CH         = 4,
  parameter int  TIMEOUT_CYCLES = 1024,
  localparam int CH_W           = $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                rst,
  rmap_rx_arbiter_if.master   bus,
  input  logic [7:0]          logicalAddress,
  input  logic                filterEnable,
  output logic [CH_W-1:0]     activeChannel,
  output logic                busy,
  output logic [15:0]         dropCount,
  output logic                timeoutEvent
);

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 2) begin : gBadParams
    $error("rmap_rx_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, HEADER, FORWARD, DROP} state_t;

  state_t          state, stateNext;
  logic [CH_W-1:0] grant, grantNext;
  logic [CH_W-1:0] rrPtr, rrPtrNext;
  logic [8:0]      chHead [NUM_CH];
  logic [8:0]      headChar;
  logic            headValid;
  logic            canLoad;
  logic            pop;
  logic            load;
  logic [8:0]      loadData;
  logic            dropInc;
  logic            found;
  int              idx;
  logic [8:0]      hold;
  logic            holdValid;

`ifdef RMAP_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmoCnt;
  logic             tmoHit;
  logic             tmoFire;
  assign tmoHit = (tmoCnt == TMO_W'(TIMEOUT_CYCLES));
`endif

  function automatic logic [CH_W-1:0] nextCh(input logic [CH_W-1:0] ch);
    return CH_W'((int'(ch) + 1) % NUM_CH);
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      chHead[i] = bus.chDataOut[9*i +: 9];
    end
  end

  assign headChar  = chHead[grant];
  assign headValid = !bus.chEmpty[grant];
  // A consumer read frees the register in the same cycle, so a held stream runs at full rate.
  assign canLoad   = !holdValid || bus.rxReadEnable;

  always_comb begin
    stateNext = state;
    grantNext = grant;
    rrPtrNext = rrPtr;
    pop       = 1'b0;
    load      = 1'b0;
    loadData  = headChar;
    dropInc   = 1'b0;
    found     = 1'b0;
    idx       = 0;
`ifdef RMAP_RX_TIMEOUT_EN
    tmoFire   = 1'b0;
`endif
    case (state)
      IDLE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          idx = (int'(rrPtr) + i) % NUM_CH;
          if (!found && !bus.chEmpty[idx]) begin
            found     = 1'b1;
            grantNext = CH_W'(idx);
          end
        end
        if (found) stateNext = HEADER;
      end
      HEADER: begin
        if (headValid) begin
          if (headChar[8]) begin
            pop       = 1'b1;
            dropInc   = 1'b1;
            stateNext = IDLE;
          end else if (filterEnable && (headChar[7:0] != logicalAddress)) begin
            pop       = 1'b1;
            stateNext = DROP;
          end else if (canLoad) begin
            pop       = 1'b1;
            load      = 1'b1;
            stateNext = FORWARD;
          end
        end
      end
      FORWARD: begin
        if (headValid && canLoad) begin
          pop  = 1'b1;
          load = 1'b1;
          if (headChar[8]) stateNext = IDLE;
        end
`ifdef RMAP_RX_TIMEOUT_EN
        else if (tmoHit && canLoad) begin
          load      = 1'b1;
          loadData  = 9'h101;
          tmoFire   = 1'b1;
          stateNext = IDLE;
        end
`endif
      end
      DROP: begin
        if (headValid) begin
          pop = 1'b1;
          if (headChar[8]) begin
            dropInc   = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    if (stateNext == IDLE && state != IDLE) rrPtrNext = nextCh(grant);
  end

  // Pops are suppressed while reset is held so a partial packet is not consumed during reset.
  always_comb begin
    bus.chReadEnable = '0;
    if (pop && rst) bus.chReadEnable[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      rrPtr     <= '0;
      hold      <= 9'h000;
      holdValid <= 1'b0;
      dropCount <= 16'd0;
    end else begin
      state     <= stateNext;
      grant     <= grantNext;
      rrPtr     <= rrPtrNext;
      if (load) hold <= loadData;
      holdValid <= load || (holdValid && !bus.rxReadEnable);
      if (dropInc) dropCount <= satInc(dropCount);
    end
  end

`ifdef RMAP_RX_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmoCnt       <= '0;
      timeoutEvent <= 1'b0;
    end else begin
      timeoutEvent <= tmoFire;
      if (state != FORWARD || pop) tmoCnt <= '0;
      else if (!headValid && !tmoHit) tmoCnt <= tmoCnt + 1'b1;
    end
  end
`else
  assign timeoutEvent = 1'b0;
`endif

  assign bus.rxDataOut = hold;
  assign bus.rxEmpty   = !holdValid;
  assign activeChannel = grant;
  assign busy          = (state != IDLE);

endmodule
